// File: rtl/ps2_host_tx_if.sv
// Signal bundle between a PS/2 command source, the host transmitter and the
// open-drain PS/2 pins.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       rx_inhibit;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    // master: command source plus the resolved line levels seen from outside
    modport master (
        output tx_data, tx_req, ps2_clk_i, ps2_dat_i,
        input  tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_dat_oe
    );

    modport slave (
        input  tx_data, tx_req, ps2_clk_i, ps2_dat_i,
        output tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device clock falls, then check the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILT_LEN       = 4
) (
    input  logic           clk,
    input  logic           reset,
    ps2_host_tx_if.slave   bus
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FL_W  = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_INHIBIT, ST_REQ, ST_BITS, ST_ACK, ST_WAIT_IDLE, ST_DONE, ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        clk_s_q, dat_s_q;
    logic              filt_q, filt_d;
    logic [FL_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic              fall_q;
    logic [9:0]        frame_q;
    logic              out_bit_q;
    logic [3:0]        n_q;
    logic [INH_W-1:0]  inh_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic inh_last, inh_sat, to_hit, to_sat;
    assign inh_last = (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1));
    assign inh_sat  = (inh_cnt_q == INH_W'(INHIBIT_CYCLES));
    assign to_hit   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign to_sat   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Clock filter: flip only after FILT_LEN consecutive differing samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s_q[1] != filt_q) begin
            if (filt_cnt_q == FL_W'(FILT_LEN - 1))
                filt_d = clk_s_q[1];
            else
                filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s_q    <= 2'b11;
            dat_s_q    <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_s_q    <= {clk_s_q[0], bus.ps2_clk_i};
            dat_s_q    <= {dat_s_q[0], bus.ps2_dat_i};
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= filt_q & ~filt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Timeout is tested before the fall so it wins a same-cycle collision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (bus.tx_req) state_d = ST_INHIBIT;
            ST_INHIBIT:   if (inh_last) state_d = ST_REQ;
            ST_REQ: begin
                if (to_hit)      state_d = ST_ERR;
                else if (fall_q) state_d = ST_BITS;
            end
            ST_BITS: begin
                if (to_hit)                        state_d = ST_ERR;
                else if (fall_q && n_q == 4'd9)    state_d = ST_ACK;
            end
            ST_ACK: begin
                if (to_hit)      state_d = ST_ERR;
                else if (fall_q) state_d = dat_s_q[1] ? ST_ERR : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (to_hit)                        state_d = ST_ERR;
                else if (filt_q && dat_s_q[1])     state_d = ST_DONE;
            end
            ST_DONE:      state_d = ST_IDLE;
            ST_ERR:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q   <= '0;
            out_bit_q <= 1'b1;
            n_q       <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.tx_req) begin
                        frame_q   <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        inh_cnt_q <= '0;
                    end
                end
                ST_INHIBIT: begin
                    if (!inh_sat) inh_cnt_q <= inh_cnt_q + 1'b1;
                    to_cnt_q  <= '0;
                    n_q       <= '0;
                    out_bit_q <= 1'b1;
                end
                ST_REQ, ST_BITS, ST_ACK, ST_WAIT_IDLE: begin
                    if (!to_sat) to_cnt_q <= to_cnt_q + 1'b1;
                    if (fall_q && state_q != ST_WAIT_IDLE) begin
                        n_q <= n_q + 4'd1;
                        // frame shifts out LSB first: data, parity, stop
                        if (state_q != ST_ACK) begin
                            out_bit_q <= frame_q[0];
                            frame_q   <= {1'b0, frame_q[9:1]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.tx_ready   = (state_q == ST_IDLE);
        bus.rx_inhibit = (state_q != ST_IDLE);
        bus.tx_done    = (state_q == ST_DONE);
        bus.tx_err     = (state_q == ST_ERR);
        bus.ps2_clk_oe = (state_q == ST_INHIBIT);
        bus.ps2_dat_oe = ((state_q == ST_INHIBIT) && inh_last) ||
                         (state_q == ST_REQ) ||
                         (((state_q == ST_BITS) || (state_q == ST_ACK)) && !out_bit_q);
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-keyboard PS/2 command transmitter. It is the opposite direction to the scancode path into the keyboard translator.
- Sends single command/data bytes to the keyboard, e.g. 0xED LED set for the RUS/LAT indicator, 0xFF reset, 0xF3 typematic.
- Drives open-drain PS/2 clock/data through output-enable pins.
- Raises rx_inhibit so the PS/2 receiver ignores bus activity during a host transfer.

Parameters:
INHIBIT_CYCLES, 2500, clk cycles the host holds PS/2 clock low before a request (≥100 us; 2500 = 100 us at 25 MHz)
TIMEOUT_CYCLES, 375000, max clk cycles from clock release to ack completion (15 ms at 25 MHz)
FILT_LEN, 4, consecutive equal synchronized samples required to accept a new ps2_clk level

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tx_data  in  8  byte to send; sampled on accept
tx_req  in  1  request strobe; accepted only when tx_ready=1
tx_ready  out  1  high in IDLE only
tx_done  out  1  one-cycle pulse: byte acknowledged by device
tx_err  out  1  one-cycle pulse: timeout or missing ack
rx_inhibit  out  1  high whenever state != IDLE
ps2_clk_i  in  1  PS/2 clock line level (async)
ps2_dat_i  in  1  PS/2 data line level (async)
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_dat_oe  out  1  1 = pull PS/2 data low

Behaviour:
- Reset (async): state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, tx_done=0, tx_err=0, rx_inhibit=0; counters and shift register cleared. Lines are released immediately, including mid-transfer.
- Input conditioning: 2-flop synchronizer on both inputs. The filtered clock changes level only after FILT_LEN consecutive equal synchronized samples. fall = filtered clock 1->0, one-cycle pulse. Glitches shorter than FILT_LEN are ignored.
- Accept: tx_req=1 in IDLE latches frame {stop=1, parity=~^tx_data, tx_data}. Next state INHIBIT. Requests outside IDLE are ignored (no queue).
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. On the last cycle ps2_dat_oe=1 (start bit). Next state REQ.
- REQ: ps2_clk_oe=0, ps2_dat_oe=1. The timeout counter starts from 0. The bit counter n=0.
- BITS: on each fall, n=1..8 drives data bit n-1 (LSB first), n=9 drives parity, n=10 drives stop. Drive means ps2_dat_oe = ~bit, so stop means released. The output is updated the cycle after the fall pulse.
- ACK: at fall n=11, sample the synchronized data. 0 -> WAIT_IDLE. 1 -> ERR.
- WAIT_IDLE: wait until filtered clock=1 and synchronized data=1, then DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- ERR: both oe=0, tx_err=1 for one cycle, then IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, BITS, ACK or WAIT_IDLE, go to ERR. This takes priority over a simultaneous fall.
- tx_done and tx_err never assert together. tx_ready rises in the cycle after the DONE or ERR pulse.
- rx_inhibit=1 from INHIBIT through DONE/ERR inclusive.
- The counters are sized by $clog2 of their parameter and saturate; they never wrap.

Test Plan:
1. Send 0xED with a device model (clock period 80 us, ack driven). Required response:
   - device samples on rising edges: 0,1,0,1,1,0,1,1,1,1,1 (start, data LSB-first, parity=1, stop);
   - tx_done pulses exactly 1 cycle;
   - tx_ready returns high;
   - both oe=0.
2. Inhibit timing with default parameters: ps2_clk_oe is high for exactly 2500 cycles; ps2_dat_oe rises on the 2500th cycle; rx_inhibit is high throughout.
3. Device never clocks after REQ: tx_err pulses at 375000 cycles after clock release, tx_done stays 0, both lines released.
4. Device leaves data high at the 11th fall (no ack): tx_err pulses, no tx_done.
5. tx_req=1 with tx_data=0x55 during an active 0xFF transfer: ignored. The 0xFF frame completes unchanged (parity bit 1). Only one tx_done.
6. Two cases:
   - 2-cycle low glitch on ps2_clk_i mid-frame: bit count is unchanged and the frame is correct.
   - reset asserted mid-BITS: ps2_clk_oe and ps2_dat_oe go 0 without waiting for clk; after release tx_ready=1.
